seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Parametrised multiplexed seven-segment display controller for the board's two 4-digit banks. Accepts a binary value on a load strobe and shows it in hexadecimal, or in decimal through a sequential double-dabble converter. Time-multiplexes `NUM_DIGITS` digits with a programmable scan rate, optional leading-zero blanking, and an overflow flag. It sits beside the CPU top-level and is driven by the MMIO display register.

## Interface
- `NUM_DIGITS`, 8: digits scanned; the value must be even.
- `BANK_SPLIT`, 4: digits `0..BANK_SPLIT-1` drive `seg0`, and the remaining digits drive `seg1`.
- `DIN_WIDTH`, 32: width of the binary input.
- `SCAN_DIV`, 50000: `clk` cycles per digit slot. The value must be at least 2.

Ports:
- `clk` in 1: the single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: 0 blanks the whole display.
- `load` in 1: one-cycle strobe that samples `num`, `mode` and `blank_lz`.
- `num` in `DIN_WIDTH`: value to display.
- `mode` in 1: 0 selects hex, 1 selects decimal.
- `blank_lz` in 1: 1 suppresses leading zeros.
- `busy` out 1: a decimal conversion is in progress.
- `ovf` out 1: the displayed decimal value was truncated.
- `seg0` out 8: low-bank segments {a,b,c,d,e,f,g,dp}, active-high.
- `seg1` out 8: high-bank segments, same encoding as `seg0`.
- `an` out `NUM_DIGITS`: one-hot digit enable, active-high. Bit i selects digit i, and digit 0 is least significant.

## Operation
- **Reset.** All of the following clear to 0:
  - `busy`, `ovf`, `seg0`, `seg1`, `an`.
  - The display register (`NUM_DIGITS` × 4 bits), the scan counter and the digit index.
  - A reset during a conversion aborts it and discards the partial result.
- **Load FSM.** States are IDLE and CONV. A `load` in IDLE captures `num`, `mode` and `blank_lz`.
  - Hex mode:
    - The display register receives `num[4*NUM_DIGITS-1:0]` on the next edge. Any higher bits of `num` are ignored.
    - `ovf` is set to 0. The FSM stays in IDLE.
  - Decimal mode:
    - Go to CONV and assert `busy`.
    - Run one double-dabble step per cycle, MSB first. Each step adds 3 to every BCD nibble that is ≥ 5, then shifts left one bit.
    - The BCD working register is wide enough for the full `DIN_WIDTH` value (10 digits at 32 bits).
    - After `DIN_WIDTH` steps, the low `NUM_DIGITS` BCD digits are written to the display register in a single update.
    - `ovf` is set to 1 if any higher BCD digit is nonzero. The FSM returns to IDLE.
  - A `load` in CONV is ignored, with no queueing.
  - A `load` in the same cycle that CONV completes is also ignored.
- **Scan.**
  - The counter runs from 0 to `SCAN_DIV-1`. On the wrap cycle it generates a tick, and the digit index increments, wrapping from `NUM_DIGITS-1` to 0.
  - `an` is the one-hot encoding of the digit index.
  - The bus of the bank that owns the current digit carries that digit's encoding. The other bank's bus is 8'h00.
- **Encoding.** 0→FC, 1→60, 2→DA, 3→F2, 4→66, 5→B6, 6→BE, 7→E0, 8→FE, 9→F6, A→EE, B→3E, C→9C, D→7A, E→9E, F→8E.
- **Leading-zero blanking.**
  - Applies when the latched `blank_lz` is 1.
  - Digit i > 0 outputs 8'h00 when it and all digits above it are 0.
  - Digit 0 is never blanked.
  - `an` still asserts for a blanked digit.
- **Enable.**
  - `enable` = 0 forces `an`, `seg0` and `seg1` to 0.
  - Scanning and conversion keep running while disabled.
  - The display resumes at the current index when `enable` returns to 1.

## Timing
- Hex load: the new digits are visible on `seg`/`an` from the first scan slot that starts ≥ 1 cycle after `load`.
- Decimal load:
  - `busy` rises 1 cycle after `load` and stays high for exactly `DIN_WIDTH` cycles.
  - The display register and `ovf` update on the edge where `busy` falls.
- `an`, `seg0` and `seg1` are registered and change 1 cycle after the tick cycle.
- Every digit is refreshed once per `NUM_DIGITS` × `SCAN_DIV` cycles.
- The display register never shows a partial conversion: the old value holds until the single-cycle update.
- `enable` takes effect on outputs 1 cycle after it changes, because the outputs are registered.

## Structure
- Package `seg_pkg`:
  - The 16-entry segment encoding constant, or an `f_seg_encode` function.
  - The mode constants `MODE_HEX`/`MODE_DEC`.
  - The FSM state typedef.
- Sub-module `bin2bcd_seq`:
  - Parameters `DIN_WIDTH`, `BCD_DIGITS`.
  - Ports: `start`, `din`, `busy`, `done` (1-cycle), `bcd`.
  - It owns the shift/add-3 datapath.
- The top level holds the load FSM, the display register, blanking, the scan counter and the bank steering.

## Test plan
All scenarios use `SCAN_DIV=4`, `NUM_DIGITS=8`, `DIN_WIDTH=32`.
- **Hex load.** `load` with `mode=0`, `num=32'h1234_5678` → digit 0 shows 8'hFE on `seg0` (`an`=8'h01) and digit 7 shows 8'h60 on `seg1` (`an`=8'h80). `busy` stays 0.
- **Decimal load.** `load` with `mode=1`, `num=12345678` → `busy` is high for 32 cycles. Digits 0..7 then read 8,7,6,5,4,3,2,1, and `ovf`=0.
- **Overflow.** `mode=1`, `num=32'hFFFF_FFFF` → the digits read 94967295 and `ovf`=1.
- **Blanking.** `mode=1`, `blank_lz=1`, `num=0` → digit 0 shows 8'hFC, digits 1..7 show 8'h00, and `an` still cycles through all bits.
- **Load during conversion.** A second `load` 5 cycles into a conversion is ignored: the first value is displayed and `busy` falls after 32 cycles.
- **Reset mid-conversion.** `rst` asserted during CONV → next cycle all outputs are 0 and the FSM is in IDLE.
- **Enable.** `enable`=0 → `an`=0 and `seg0`=`seg1`=0, and the scan index keeps advancing.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment display controller.
package seg_pkg;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } state_t;

  // Segment order {a,b,c,d,e,f,g,dp}, active-high.
  function automatic logic [7:0] f_seg_encode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Decimal digits needed for a w-bit unsigned value: ceil(w * log10(2)).
  function automatic int unsigned f_bcd_digits(input int unsigned w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, MSB first.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = 32,
  parameter int unsigned BCD_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIN_WIDTH-1:0]    din,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int unsigned CNT_W = $clog2(DIN_WIDTH + 1);

  logic                    busy_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DIN_WIDTH-1:0]    bin_q, bin_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, adj;

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_d, bin_d} = {adj, bin_q} << 1;
  end

  // bcd carries the post-step value so the final step is usable on the done edge.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(DIN_WIDTH - 1));
  assign bcd  = bcd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
    end else if (busy_q) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      bin_q  <= din;
      bcd_q  <= '0;
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Seven-segment scan controller: load FSM, display register, blanking, scan and bank steering.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BANK_SPLIT = 4,
  parameter int unsigned DIN_WIDTH  = 32,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [DIN_WIDTH-1:0]  num,
  input  logic                  mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  ovf,
  output logic [7:0]            seg0,
  output logic [7:0]            seg1,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned DISP_W     = 4 * NUM_DIGITS;
  localparam int unsigned BCD_DIGITS = (f_bcd_digits(DIN_WIDTH) > NUM_DIGITS) ?
                                       f_bcd_digits(DIN_WIDTH) : NUM_DIGITS + 1;
  localparam int unsigned EXT_W      = (DIN_WIDTH > DISP_W) ? DIN_WIDTH : DISP_W;
  localparam int unsigned CNT_W      = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  state_t                  state_q, state_d;
  logic                    hex_load, dec_start;
  logic                    conv_busy, conv_done;
  logic [4*BCD_DIGITS-1:0] conv_bcd;
  logic [EXT_W-1:0]        num_ext;

  logic [DISP_W-1:0]       disp_q;
  logic                    ovf_q, blz_q, blz_pend_q;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tick;

  logic [NUM_DIGITS-1:0]   zero_above;
  logic [3:0]              digit;
  logic [7:0]              seg_val, seg0_d, seg1_d, seg0_q, seg1_q;
  logic [NUM_DIGITS-1:0]   an_d, an_q;

  bin2bcd_seq #(
    .DIN_WIDTH (DIN_WIDTH),
    .BCD_DIGITS(BCD_DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .start(dec_start),
    .din  (num),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load && mode == MODE_DEC) state_d = ST_CONV;
      ST_CONV: if (conv_done || !conv_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_CONV);
    hex_load  = (state_q == ST_IDLE) && load && (mode == MODE_HEX);
    dec_start = (state_q == ST_IDLE) && load && (mode == MODE_DEC);
  end

  always_comb num_ext = EXT_W'(num);

  // Blanking choice for a decimal load is held aside until the result lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      blz_q      <= 1'b0;
      blz_pend_q <= 1'b0;
    end else begin
      if (dec_start) blz_pend_q <= blank_lz;
      if (hex_load) begin
        disp_q <= num_ext[DISP_W-1:0];
        ovf_q  <= 1'b0;
        blz_q  <= blank_lz;
      end else if (state_q == ST_CONV && conv_done) begin
        disp_q <= conv_bcd[DISP_W-1:0];
        ovf_q  <= |conv_bcd[4*BCD_DIGITS-1:DISP_W];
        blz_q  <= blz_pend_q;
      end
    end
  end

  always_comb begin
    tick  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  always_comb begin
    zero_above = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (j == 0) zero_above[NUM_DIGITS-1] = (disp_q[DISP_W-1 -: 4] == 4'h0);
      else zero_above[NUM_DIGITS-1-j] = zero_above[NUM_DIGITS-j] &&
                                        (disp_q[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
    end
    digit   = disp_q[4*idx_d +: 4];
    seg_val = (blz_q && idx_d != '0 && zero_above[idx_d]) ? 8'h00 : f_seg_encode(digit);
    an_d    = '0;
    seg0_d  = '0;
    seg1_d  = '0;
    if (enable) begin
      an_d[idx_d] = 1'b1;
      if (32'(idx_d) < BANK_SPLIT) seg0_d = seg_val;
      else                         seg1_d = seg_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= '0;
      seg0_q <= '0;
      seg1_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg0_q <= seg0_d;
      seg1_q <= seg1_d;
    end
  end

  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg0 = seg0_q;
  assign seg1 = seg1_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed scoreboard bench for seg_scan_display with a fast scan rate.
module tb_seg_scan_display;

  localparam int ND = 8;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst, enable, load, mode, blank_lz;
  logic [31:0]   num;
  logic          busy, ovf;
  logic [7:0]    seg0, seg1;
  logic [ND-1:0] an;

  int checks = 0;
  int errors = 0;
  int n;
  logic [23:0] sb[$];
  logic [7:0]  seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  seg_scan_display #(
    .NUM_DIGITS(8),
    .BANK_SPLIT(4),
    .DIN_WIDTH (32),
    .SCAN_DIV  (SD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .load    (load),
    .num     (num),
    .mode    (mode),
    .blank_lz(blank_lz),
    .busy    (busy),
    .ovf     (ovf),
    .seg0    (seg0),
    .seg1    (seg1),
    .an      (an)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dec_digits(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic push_disp(input logic [31:0] nibs, input logic blz);
    logic [7:0] s;
    logic [7:0] a;
    for (int k = 0; k < ND; k++) begin
      s = seg_tab[nibs[4*k +: 4]];
      if (blz && k > 0 && (nibs >> (4*k)) == 32'd0) s = 8'h00;
      a = 8'h01 << k;
      if (k < 4) sb.push_back({a, 8'h00, s});
      else       sb.push_back({a, s, 8'h00});
    end
  endtask

  task automatic wait_slot0(input string tag);
    int c;
    c = 0;
    while (an == 8'h01 && c < 200) begin @(negedge clk); c++; end
    while (an != 8'h01 && c < 200) begin @(negedge clk); c++; end
    chk({tag, "_slot0_timeout"}, {24'd0, an}, 32'h01);
  endtask

  task automatic check_slots(input string tag);
    logic [23:0] w;
    wait_slot0(tag);
    for (int k = 0; k < ND; k++) begin
      w = sb.pop_front();
      chk($sformatf("%s_digit%0d", tag, k), {8'd0, an, seg1, seg0}, {8'd0, w});
      repeat (SD) @(negedge clk);
    end
  endtask

  task automatic do_load(input logic m, input logic [31:0] v, input logic b);
    @(negedge clk);
    load = 1'b1; mode = m; num = v; blank_lz = b;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; @(negedge clk); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0; mode = 1'b0; blank_lz = 1'b0; num = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    chk("rst_an",   {24'd0, an},   32'd0);
    chk("rst_seg0", {24'd0, seg0}, 32'd0);
    chk("rst_seg1", {24'd0, seg1}, 32'd0);
    rst = 1'b0;

    do_load(1'b0, 32'h1234_5678, 1'b0);
    chk("hex_busy", {31'd0, busy}, 32'd0);
    chk("hex_ovf",  {31'd0, ovf},  32'd0);
    push_disp(32'h1234_5678, 1'b0);
    check_slots("hex");
    chk("hex_busy_after", {31'd0, busy}, 32'd0);

    do_load(1'b1, 32'd12345678, 1'b0);
    count_busy(n);
    chk("dec_busy_len", n, 32'd32);
    chk("dec_ovf", {31'd0, ovf}, 32'd0);
    push_disp(dec_digits(32'd12345678), 1'b0);
    check_slots("dec");

    do_load(1'b1, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
    chk("ovf_busy_len", n, 32'd32);
    chk("ovf_flag", {31'd0, ovf}, 32'd1);
    push_disp(dec_digits(32'hFFFF_FFFF), 1'b0);
    check_slots("ovf");

    do_load(1'b1, 32'd0, 1'b1);
    count_busy(n);
    chk("blz_busy_len", n, 32'd32);
    chk("blz_ovf", {31'd0, ovf}, 32'd0);
    push_disp(32'd0, 1'b1);
    check_slots("blz");

    do_load(1'b1, 32'd87654321, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 5) begin load = 1'b1; mode = 1'b1; num = 32'd11; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    chk("ldconv_busy_len", n, 32'd32);
    repeat (3) @(negedge clk);
    chk("ldconv_no_restart", {31'd0, busy}, 32'd0);
    chk("ldconv_ovf", {31'd0, ovf}, 32'd0);
    push_disp(dec_digits(32'd87654321), 1'b0);
    check_slots("ldconv");

    do_load(1'b1, 32'd99, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ovf",  {31'd0, ovf},  32'd0);
    chk("midrst_an",   {24'd0, an},   32'd0);
    chk("midrst_seg0", {24'd0, seg0}, 32'd0);
    chk("midrst_seg1", {24'd0, seg1}, 32'd0);
    rst = 1'b0;
    push_disp(32'd0, 1'b0);
    check_slots("midrst_disp");
    chk("midrst_busy_after", {31'd0, busy}, 32'd0);

    wait_slot0("en");
    enable = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      chk($sformatf("en_off_t%0d", t), {8'd0, an, seg1, seg0}, 32'd0);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("en_resume", {8'd0, an, seg1, seg0}, {8'd0, 8'h04, 8'h00, 8'hFC});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
